// File: rtl/cpu_pkg.sv
// Shared core types: architectural word width, register address width and
// the matching typedefs used by the register file and its users.
package cpu_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   typedef logic [REG_AW-1:0] reg_addr_t;
   typedef logic [XLEN-1:0]   word_t;

endpackage

// File: rtl/mux_gen.sv
// Generic 2**N-to-1 word selector over an unpacked register array.
// Pure combinational; the caller applies any bypass or zero-register override.
module mux_gen
   import cpu_pkg::*;
#(
   parameter int WIDTH = XLEN,
   parameter int N     = REG_AW
) (
   input  logic [WIDTH-1:0] data [2**N],
   input  logic [N-1:0]     sel,
   output logic [WIDTH-1:0] out
);

   assign out = data[sel];

endmodule

// File: rtl/reg_file_sb.sv
// Integer register file with a pending-write scoreboard.
// Two combinational read ports with same-cycle writeback bypass, one write
// port, and one busy bit per register that the issue stage uses to stall on
// RAW hazards (source busy) and WAW hazards (destination busy).
module reg_file_sb
   import cpu_pkg::*;
#(
   parameter int WIDTH = XLEN,
   parameter int N     = REG_AW
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     rs1_addr,
   input  logic [N-1:0]     rs2_addr,
   output logic [WIDTH-1:0] rs1_data,
   output logic [WIDTH-1:0] rs2_data,
   output logic             rs1_busy,
   output logic             rs2_busy,
   input  logic             we,
   input  logic [N-1:0]     wa,
   input  logic [WIDTH-1:0] wd,
   input  logic             iss_valid,
   input  logic [N-1:0]     iss_rd,
   output logic             stall
);

   localparam int NREG = 2**N;

   logic [WIDTH-1:0] regs [NREG];
   logic [NREG-1:0]  busy;

   logic [WIDTH-1:0] raw1;
   logic [WIDTH-1:0] raw2;
   logic             byp1;
   logic             byp2;
   logic             waw;
   logic             issue_fire;
   logic             write_fire;

   // Raw array reads; bypass and x0 forcing are layered on afterwards.
   mux_gen #(.WIDTH(WIDTH), .N(N)) u_mux_rs1 (
      .data (regs),
      .sel  (rs1_addr),
      .out  (raw1)
   );

   mux_gen #(.WIDTH(WIDTH), .N(N)) u_mux_rs2 (
      .data (regs),
      .sel  (rs2_addr),
      .out  (raw2)
   );

   // Operand selection, busy reporting and the issue stall decision.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a variable unassigned and no latch can be inferred.
      rs1_data   = '0;
      rs2_data   = '0;
      rs1_busy   = 1'b0;
      rs2_busy   = 1'b0;
      waw        = 1'b0;
      stall      = 1'b0;
      issue_fire = 1'b0;

      write_fire = we && (wa != '0);
      byp1       = we && (wa == rs1_addr);
      byp2       = we && (wa == rs2_addr);

      if (rs1_addr != '0) begin
         rs1_data = byp1 ? wd : raw1;
         rs1_busy = busy[rs1_addr] && !byp1;
      end
      if (rs2_addr != '0) begin
         rs2_data = byp2 ? wd : raw2;
         rs2_busy = busy[rs2_addr] && !byp2;
      end

      // A writeback landing this cycle on the destination resolves the WAW.
      waw        = (iss_rd != '0) && busy[iss_rd] && !(we && (wa == iss_rd));
      stall      = iss_valid && (rs1_busy || rs2_busy || waw);
      issue_fire = iss_valid && !stall && (iss_rd != '0);
   end

   // Register storage and scoreboard update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the array is reset explicitly because reset must make every
         // register read back as zero; this forces flops rather than RAM.
         for (int r = 0; r < NREG; r++) begin
            regs[r] <= '0;
         end
         busy <= '0;
      end else begin
         // NOTE: state is updated with non-blocking assignments; the later
         // set below therefore overrides the clear when both hit one register,
         // which is exactly the "new issue wins" rule.
         if (write_fire) begin
            regs[wa] <= wd;
            busy[wa] <= 1'b0;
         end
         if (issue_fire) begin
            busy[iss_rd] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: a register/scoreboard model built from
// the architectural rules, a per-cycle comparison against it, and directed
// vectors with literal expectations.
module tb_reg_file_sb;
   import cpu_pkg::*;

   localparam int NREG = 2**REG_AW;

   logic      clk = 1'b0;
   logic      rst_n = 1'b0;
   reg_addr_t rs1_addr = '0;
   reg_addr_t rs2_addr = '0;
   word_t     rs1_data;
   word_t     rs2_data;
   logic      rs1_busy;
   logic      rs2_busy;
   logic      we = 1'b0;
   reg_addr_t wa = '0;
   word_t     wd = '0;
   logic      iss_valid = 1'b0;
   reg_addr_t iss_rd = '0;
   logic      stall;

   int n_tests = 0;
   int n_fail  = 0;

   word_t m_regs [NREG];
   logic  m_busy [NREG];

   reg_file_sb #(.WIDTH(XLEN), .N(REG_AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rs1_addr  (rs1_addr),
      .rs2_addr  (rs2_addr),
      .rs1_data  (rs1_data),
      .rs2_data  (rs2_data),
      .rs1_busy  (rs1_busy),
      .rs2_busy  (rs2_busy),
      .we        (we),
      .wa        (wa),
      .wd        (wd),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .stall     (stall)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Model view of the read ports and stall, from the architectural rules.
   function automatic word_t exp_data(input reg_addr_t a);
      if (a == 0) return '0;
      if (we && wa == a) return wd;
      return m_regs[a];
   endfunction

   function automatic logic exp_busy(input reg_addr_t a);
      if (a == 0) return 1'b0;
      return m_busy[a] && !(we && wa == a);
   endfunction

   function automatic logic exp_stall();
      logic w;
      w = (iss_rd != 0) && m_busy[iss_rd] && !(we && wa == iss_rd);
      return iss_valid && (exp_busy(rs1_addr) || exp_busy(rs2_addr) || w);
   endfunction

   // Model state update: per-register set/clear table, set wins.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++) begin
            m_regs[r] <= '0;
            m_busy[r] <= 1'b0;
         end
      end else begin
         for (int r = 1; r < NREG; r++) begin
            if (we && wa == r) m_regs[r] <= wd;
            if (iss_valid && !exp_stall() && iss_rd == r) m_busy[r] <= 1'b1;
            else if (we && wa == r)                       m_busy[r] <= 1'b0;
         end
      end
   end

   // Every cycle out of reset, compare all outputs with the model.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         check("cmp_rs1_data", rs1_data, exp_data(rs1_addr));
         check("cmp_rs2_data", rs2_data, exp_data(rs2_addr));
         check("cmp_rs1_busy", {31'b0, rs1_busy}, {31'b0, exp_busy(rs1_addr)});
         check("cmp_rs2_busy", {31'b0, rs2_busy}, {31'b0, exp_busy(rs2_addr)});
         check("cmp_stall",    {31'b0, stall},    {31'b0, exp_stall()});
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = 1'b0; wa = '0; wd = '0; iss_valid = 1'b0; iss_rd = '0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // 1. After reset every address reads zero, not busy, no stall.
      for (int i = 0; i < NREG; i++) begin
         next_cycle();
         rs1_addr = reg_addr_t'(i); rs2_addr = reg_addr_t'(NREG - 1 - i);
         iss_valid = 1'b1; iss_rd = '0;
         #1;
         check("rst_rs1_data", rs1_data, 32'h0);
         check("rst_rs2_data", rs2_data, 32'h0);
         check("rst_rs1_busy", {31'b0, rs1_busy}, 32'h0);
         check("rst_rs2_busy", {31'b0, rs2_busy}, 32'h0);
         check("rst_stall",    {31'b0, stall},    32'h0);
      end

      // 2. Write with same-cycle bypass, then stored value.
      next_cycle(); idle();
      we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF; rs1_addr = 5'd5; rs2_addr = 5'd6;
      #1 check("byp_rs1", rs1_data, 32'hDEAD_BEEF);
      next_cycle(); idle();
      #1 check("stored_rs1", rs1_data, 32'hDEAD_BEEF);

      // 3. Writes to x0 are ignored, including the bypass path.
      next_cycle(); idle();
      we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; rs2_addr = 5'd0; rs1_addr = 5'd0;
      #1 check("x0_byp", rs2_data, 32'h0);
      next_cycle(); idle();
      #1 check("x0_next", rs2_data, 32'h0);

      // 4. RAW stall on a pending destination, released by writeback bypass.
      next_cycle(); idle();
      iss_valid = 1'b1; iss_rd = 5'd7; rs1_addr = 5'd5; rs2_addr = 5'd0;
      #1 check("iss7_accept", {31'b0, stall}, 32'h0);
      next_cycle(); idle();
      iss_valid = 1'b1; iss_rd = 5'd2; rs1_addr = 5'd7;
      #1 check("raw_busy", {31'b0, rs1_busy}, 32'h1);
      check("raw_stall", {31'b0, stall}, 32'h1);
      we = 1'b1; wa = 5'd7; wd = 32'd42;
      #1 check("wb_busy", {31'b0, rs1_busy}, 32'h0);
      check("wb_data", rs1_data, 32'd42);
      check("wb_stall", {31'b0, stall}, 32'h0);
      next_cycle(); idle();
      rs1_addr = 5'd7; rs2_addr = 5'd2;
      #1 check("r7_free", {31'b0, rs1_busy}, 32'h0);
      check("r2_set", {31'b0, rs2_busy}, 32'h1);
      we = 1'b1; wa = 5'd2; wd = 32'h0000_0222;
      next_cycle(); idle();

      // 5. Issue and writeback on the same register: busy stays set; WAW stalls.
      next_cycle(); idle();
      iss_valid = 1'b1; iss_rd = 5'd3; we = 1'b1; wa = 5'd3; wd = 32'h33;
      rs1_addr = 5'd0; rs2_addr = 5'd0;
      next_cycle(); idle();
      rs1_addr = 5'd3;
      #1 check("setclr_busy", {31'b0, rs1_busy}, 32'h1);
      check("setclr_data", rs1_data, 32'h33);
      rs1_addr = 5'd0; iss_valid = 1'b1; iss_rd = 5'd3;
      #1 check("waw_stall", {31'b0, stall}, 32'h1);
      next_cycle(); idle();
      rs2_addr = 5'd3;
      #1 check("waw_hold", {31'b0, rs2_busy}, 32'h1);
      we = 1'b1; wa = 5'd3; wd = 32'h44;
      next_cycle(); idle();
      // Write to a non-busy register leaves it non-busy.
      we = 1'b1; wa = 5'd12; wd = 32'h0C0C_0C0C;
      next_cycle(); idle();
      rs1_addr = 5'd12; rs2_addr = 5'd3;
      #1 check("nb_data", rs1_data, 32'h0C0C_0C0C);
      check("nb_busy", {31'b0, rs1_busy}, 32'h0);
      check("r3_clr", {31'b0, rs2_busy}, 32'h0);

      // 6. Async reset mid-cycle clears data and busy immediately.
      next_cycle(); idle();
      we = 1'b1; wa = 5'd9; wd = 32'h1234;
      next_cycle(); idle();
      iss_valid = 1'b1; iss_rd = 5'd9;
      next_cycle(); idle();
      rs1_addr = 5'd9;
      #1 check("pre_rst_busy", {31'b0, rs1_busy}, 32'h1);
      check("pre_rst_data", rs1_data, 32'h1234);
      #1 rst_n = 1'b0;
      #1 check("rst_busy", {31'b0, rs1_busy}, 32'h0);
      check("rst_data", rs1_data, 32'h0);
      iss_valid = 1'b1; iss_rd = 5'd9;
      #1 check("rst_stall9", {31'b0, stall}, 32'h0);
      next_cycle(); idle();
      rst_n = 1'b1;
      rs1_addr = 5'd5; rs2_addr = 5'd9;
      #1 check("post_rst_r5", rs1_data, 32'h0);
      check("post_rst_b9", {31'b0, rs2_busy}, 32'h0);
      next_cycle();
      next_cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
